// File: rtl/stb_datapath_if.sv
// rtl/stb_datapath_if.sv - LSU / cache-controller bus bundle for the store buffer
interface stb_datapath_if #(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            lsu2stb_w_en;
  logic [AW-1:0]   lsu2stb_addr;
  logic [DW-1:0]   lsu2stb_data;
  logic [DW/8-1:0] lsu2stb_sel;
  logic            lsu_ld_req;
  logic [AW-1:0]   lsu_ld_addr;
  logic            stb_rd_en;
  logic            rd_sel;

  logic            stb2lsu_stall;
  logic            stb_ld_hit;
  logic            stb_full;
  logic            stb_empty;
  logic [CW-1:0]   stb_count;
  logic [AW-1:0]   stb2dcache_addr;
  logic [DW-1:0]   stb2dcache_data;
  logic [DW/8-1:0] stb2dcache_sel;

  // Requesters: LSU and cache controller
  modport master (
    output lsu2stb_w_en, lsu2stb_addr, lsu2stb_data, lsu2stb_sel,
    output lsu_ld_req, lsu_ld_addr, stb_rd_en, rd_sel,
    input  stb2lsu_stall, stb_ld_hit, stb_full, stb_empty, stb_count,
    input  stb2dcache_addr, stb2dcache_data, stb2dcache_sel
  );

  // Store buffer
  modport slave (
    input  lsu2stb_w_en, lsu2stb_addr, lsu2stb_data, lsu2stb_sel,
    input  lsu_ld_req, lsu_ld_addr, stb_rd_en, rd_sel,
    output stb2lsu_stall, stb_ld_hit, stb_full, stb_empty, stb_count,
    output stb2dcache_addr, stb2dcache_data, stb2dcache_sel
  );
endinterface

// File: rtl/stb_datapath.sv
// rtl/stb_datapath.sv - store buffer FIFO with load-overlap detection
module stb_datapath #(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  stb_datapath_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam int SW = DW / 8;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [DEPTH-1:0] valid;
  logic [AW-1:0]    addr_mem [DEPTH];
  logic [DW-1:0]    data_mem [DEPTH];
  logic [SW-1:0]    sel_mem  [DEPTH];

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic ld_hit;

  // Flags use pre-edge pointers, so a push while full stalls even with a pop
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);
  assign push  = bus.lsu2stb_w_en & ~full;
  assign pop   = bus.stb_rd_en & ~empty;

  assign bus.stb_empty     = empty;
  assign bus.stb_full      = full;
  assign bus.stb2lsu_stall = bus.lsu2stb_w_en & full;
  assign bus.stb_count     = wr_ptr - rd_ptr;
  assign bus.stb_ld_hit    = ld_hit;

  // Pointers and valid bits; reset drops every pending store
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      valid  <= '0;
    end else begin
      if (push) begin
        wr_ptr                 <= wr_ptr + 1'b1;
        valid[wr_ptr[IW-1:0]]  <= 1'b1;
      end
      if (pop) begin
        rd_ptr                 <= rd_ptr + 1'b1;
        valid[rd_ptr[IW-1:0]]  <= 1'b0;
      end
    end
  end

  // Entry payload needs no reset; valid bits gate its use
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr[IW-1:0]] <= bus.lsu2stb_addr;
      data_mem[wr_ptr[IW-1:0]] <= bus.lsu2stb_data;
      sel_mem[wr_ptr[IW-1:0]]  <= bus.lsu2stb_sel;
    end
  end

  // Head entry onto the dcache port only while the controller selects it
  always_comb begin
    bus.stb2dcache_addr = '0;
    bus.stb2dcache_data = '0;
    bus.stb2dcache_sel  = '0;
    if (bus.rd_sel) begin
      bus.stb2dcache_addr = addr_mem[rd_ptr[IW-1:0]];
      bus.stb2dcache_data = data_mem[rd_ptr[IW-1:0]];
      bus.stb2dcache_sel  = sel_mem[rd_ptr[IW-1:0]];
    end
  end

  // Word-granular overlap against registered valid entries only
  always_comb begin
    ld_hit = 1'b0;
    if (bus.lsu_ld_req) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i] && (addr_mem[i][AW-1:2] == bus.lsu_ld_addr[AW-1:2])) begin
          ld_hit = 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_stb_datapath.sv
// tb/tb_stb_datapath.sv - scoreboard bench for stb_datapath
module tb_stb_datapath;
  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int DW    = 32;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] sel;
  } entry_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  entry_t sb[$];

  stb_datapath_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  stb_datapath #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.lsu2stb_w_en = 1'b0;
    bus.lsu2stb_addr = '0;
    bus.lsu2stb_data = '0;
    bus.lsu2stb_sel  = '0;
    bus.lsu_ld_req   = 1'b0;
    bus.lsu_ld_addr  = '0;
    bus.stb_rd_en    = 1'b0;
    bus.rd_sel       = 1'b1;
  endtask

  function automatic bit model_hit(input logic [AW-1:0] a);
    foreach (sb[i]) if (sb[i].addr[AW-1:2] == a[AW-1:2]) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive, check combinational outputs mid-cycle, advance model
  task automatic step(input bit push, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [3:0] s, input bit pop);
    bit     exp_stall;
    entry_t e;
    bus.lsu2stb_w_en = push;
    bus.lsu2stb_addr = a;
    bus.lsu2stb_data = d;
    bus.lsu2stb_sel  = s;
    bus.stb_rd_en    = pop;
    bus.rd_sel       = 1'b1;
    #4;
    exp_stall = push && (sb.size() == DEPTH);
    check("stall", bus.stb2lsu_stall, exp_stall);
    check("full", bus.stb_full, sb.size() == DEPTH);
    check("empty", bus.stb_empty, sb.size() == 0);
    if (sb.size() > 0) begin
      check("head_addr", bus.stb2dcache_addr, sb[0].addr);
      check("head_data", bus.stb2dcache_data, sb[0].data);
      check("head_sel",  bus.stb2dcache_sel,  sb[0].sel);
    end
    @(posedge clk);
    #1;
    if (pop && sb.size() > 0) void'(sb.pop_front());
    if (push && !exp_stall) begin
      e.addr = a; e.data = d; e.sel = s;
      sb.push_back(e);
    end
    idle_inputs();
    check("count", bus.stb_count, sb.size());
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    rst = 1'b1;
    bus.lsu2stb_w_en = 1'b1;
    bus.lsu_ld_req   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", bus.stb_empty, 1);
    check("rst_full",  bus.stb_full, 0);
    check("rst_count", bus.stb_count, 0);
    check("rst_stall", bus.stb2lsu_stall, 0);
    check("rst_ld_hit", bus.stb_ld_hit, 0);
    idle_inputs();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single store visible on dcache port
    step(1, 32'h100, 32'hDEADBEEF, 4'hF, 0);
    check("single_addr", bus.stb2dcache_addr, 32'h100);
    check("single_data", bus.stb2dcache_data, 32'hDEADBEEF);
    check("single_sel",  bus.stb2dcache_sel, 4'hF);
    check("single_empty", bus.stb_empty, 0);
    bus.rd_sel = 1'b0;
    #1;
    check("rdsel0_addr", bus.stb2dcache_addr, 0);
    check("rdsel0_data", bus.stb2dcache_data, 0);
    bus.rd_sel = 1'b1;
    step(0, 0, 0, 0, 1);

    // Fill, then overflow attempt
    for (int i = 0; i < DEPTH; i++) step(1, 32'h1000 + 4 * i, 32'hA000 + i, 4'(i + 1), 0);
    check("fill_full", bus.stb_full, 1);
    check("fill_count", bus.stb_count, DEPTH);
    step(1, 32'hBAD0, 32'hBADBAD, 4'h1, 0);
    check("ovf_head", bus.stb2dcache_data, 32'hA000);

    // Push+pop while full: push stalls, head advances
    step(1, 32'hBAD4, 32'hBADBAD, 4'h2, 1);
    check("pp_count", bus.stb_count, DEPTH - 1);
    check("pp_head", bus.stb2dcache_data, 32'hA001);
    while (sb.size() > 0) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Alternating push/pop across the pointer wrap
    for (int i = 0; i < 12; i++) begin
      step(1, 32'h2000 + 4 * i, $urandom, 4'($urandom_range(1, 15)), 0);
      step(0, 0, 0, 0, 1);
    end
    check("wrap_empty", bus.stb_empty, 1);

    // Load overlap detection
    step(1, 32'h204, 32'h1234, 4'h3, 0);
    bus.lsu_ld_req = 1'b1;
    bus.lsu_ld_addr = 32'h206;
    #1;
    check("ld_206", bus.stb_ld_hit, model_hit(32'h206));
    check("ld_206_const", bus.stb_ld_hit, 1);
    bus.lsu_ld_addr = 32'h208;
    #1;
    check("ld_208", bus.stb_ld_hit, 0);
    bus.lsu_ld_req = 1'b0;
    bus.lsu_ld_addr = 32'h206;
    #1;
    check("ld_noreq", bus.stb_ld_hit, 0);
    step(0, 0, 0, 0, 1);
    bus.lsu_ld_req = 1'b1;
    bus.lsu_ld_addr = 32'h206;
    #1;
    check("ld_popped", bus.stb_ld_hit, 0);
    idle_inputs();

    // Reset mid-push with five pending stores
    for (int i = 0; i < 5; i++) step(1, 32'h3000 + 4 * i, 32'hC000 + i, 4'hF, 0);
    check("pre_rst_count", bus.stb_count, 5);
    bus.lsu2stb_w_en = 1'b1;
    bus.lsu2stb_addr = 32'h3100;
    bus.lsu2stb_data = 32'hC0FFEE;
    bus.lsu2stb_sel  = 4'hF;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_count", bus.stb_count, 0);
    check("mid_rst_empty", bus.stb_empty, 1);
    @(posedge clk);
    #1;
    check("rst_hold_count", bus.stb_count, 0);
    rst = 1'b0;
    idle_inputs();
    sb.delete();
    @(posedge clk);
    #1;
    step(1, 32'h900, 32'h55AA55AA, 4'h5, 0);
    check("post_rst_head", bus.stb2dcache_data, 32'h55AA55AA);
    step(0, 0, 0, 0, 1);
    check("post_rst_empty", bus.stb_empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
